// File: rtl/pipeline_if.sv
// pipeline_if: jump/write controls into the fetch-decode front end and
// the registered decode operands coming back out of it.
interface pipeline_if;
   logic        btnSelect;
   logic        btnWRselect;
   logic [31:0] jmpAddr;
   logic [31:0] dataRs;
   logic [31:0] dataRt;

   modport master (
      output btnSelect, btnWRselect, jmpAddr,
      input  dataRs, dataRt
   );

   modport slave (
      input  btnSelect, btnWRselect, jmpAddr,
      output dataRs, dataRt
   );
endinterface

// File: rtl/pipeline.sv
// pipeline: two-stage MIPS-style front end (fetch + decode) clocked by btn.
// Holds PC, a fixed 64-word instruction ROM, IF/ID, a 32x32 register file
// and the ID/EX operand registers driven onto dataRs/dataRt.
// Optional feature: define PIPELINE_BYPASS_EN to forward a same-edge
// register-file write into the operand being latched.
module pipeline (
   input  logic       btn,
   input  logic       rst,
   pipeline_if.slave  bus
);

   logic [31:0] pc;
   logic [5:0]  romK;
   logic [4:0]  romRs, romRt, romRd;
   logic [4:0]  ifRs, ifRt, ifRd;
   logic [31:0] regFile [32];
   logic [31:0] readRs, readRt;
   logic        wrEn;

   // Every ROM word is opcode 0 / shamt 0 / funct 0x20; only the register
   // fields vary, so the ROM and IF/ID carry just rs, rt and rd.
   always_comb begin
      romK  = pc[7:2];
      romRs = {romK[3:0], 1'b1};
      romRt = {romK[3:0], 1'b0} + 5'd2;
      romRd = romK[4:0] + 5'd16;
   end

   // Program counter and IF/ID register; reset loads a nop (all fields 0).
   always_ff @(posedge btn or posedge rst) begin
      if (rst) begin
         pc   <= '0;
         ifRs <= '0;
         ifRt <= '0;
         ifRd <= '0;
      end else begin
         pc   <= bus.btnSelect ? {bus.jmpAddr[31:2], 2'b00} : pc + 32'd4;
         ifRs <= romRs;
         ifRt <= romRt;
         ifRd <= romRd;
      end
   end

   assign wrEn = bus.btnWRselect && (ifRd != 5'd0);

   // Register file: reset reinitialises reg[i] = i; register 0 is never written.
   always_ff @(posedge btn or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regFile[i] <= 32'(i);
         end
      end else if (wrEn) begin
         regFile[ifRd] <= bus.jmpAddr;
      end
   end

   // Asynchronous read ports, optionally forwarding the write in flight.
   always_comb begin
      readRs = regFile[ifRs];
      readRt = regFile[ifRt];
`ifdef PIPELINE_BYPASS_EN
      if (wrEn && (ifRd == ifRs)) readRs = bus.jmpAddr;
      if (wrEn && (ifRd == ifRt)) readRt = bus.jmpAddr;
`else
      readRs = regFile[ifRs];
      readRt = regFile[ifRt];
`endif
   end

   // ID/EX operand registers.
   always_ff @(posedge btn or posedge rst) begin
      if (rst) begin
         bus.dataRs <= '0;
         bus.dataRt <= '0;
      end else begin
         bus.dataRs <= readRs;
         bus.dataRt <= readRt;
      end
   end

endmodule

// File: tb/tb_pipeline.sv
// tb_pipeline: directed and randomized stepping of the fetch/decode front
// end against an instruction-level model of PC, ROM fields and registers.
module tb_pipeline;

   logic btn;
   logic rst;
   pipeline_if bus ();

   pipeline dut (
      .btn (btn),
      .rst (rst),
      .bus (bus)
   );

   int nCmp;
   int nBad;

   // Model state
   logic [31:0] mPc;
   int          mIfRs, mIfRt, mIfRd;
   logic [31:0] mReg [32];
   logic [31:0] mRs, mRt;
   bit          mLive;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mReset();
      mPc = 32'd0;
      mIfRs = 0; mIfRt = 0; mIfRd = 0;
      for (int i = 0; i < 32; i++) mReg[i] = 32'(i);
      mRs = 32'd0;
      mRt = 32'd0;
   endtask

   // One rising edge of the architectural model.
   task automatic mStep(input bit sel, input bit wr, input logic [31:0] addr);
      logic [31:0] nRs, nRt;
      int k;
      nRs = mReg[mIfRs];
      nRt = mReg[mIfRt];
`ifdef PIPELINE_BYPASS_EN
      if (wr && mIfRd != 0 && mIfRd == mIfRs) nRs = addr;
      if (wr && mIfRd != 0 && mIfRd == mIfRt) nRt = addr;
`endif
      if (wr && mIfRd != 0) mReg[mIfRd] = addr;
      k = int'((mPc >> 2) % 64);
      mIfRs = (2 * k + 1) % 32;
      mIfRt = (2 * k + 2) % 32;
      mIfRd = (k + 16) % 32;
      mPc = sel ? (addr & 32'hFFFF_FFFC) : mPc + 32'd4;
      mRs = nRs;
      mRt = nRt;
   endtask

   // Cycle compare: outputs are stable between the rising and falling edge.
   always @(negedge btn) begin
      if (mLive && !rst) begin
         chk("cycle.dataRs", bus.dataRs, mRs);
         chk("cycle.dataRt", bus.dataRt, mRt);
      end
   end

   task automatic step(input bit sel, input bit wr, input logic [31:0] addr);
      bus.btnSelect   = sel;
      bus.btnWRselect = wr;
      bus.jmpAddr     = addr;
      mStep(sel, wr, addr);
      #5 btn = 1'b1;
      #5 btn = 1'b0;
      #2;
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      mReset();
      chk("reset.dataRs", bus.dataRs, 32'd0);
      chk("reset.dataRt", bus.dataRt, 32'd0);
      #1 rst = 1'b0;
      #2;
   endtask

   initial begin
      nCmp = 0; nBad = 0; mLive = 1'b0;
      btn = 1'b0; rst = 1'b0;
      bus.btnSelect = 1'b0; bus.btnWRselect = 1'b0; bus.jmpAddr = '0;
      mReset();
      #3;
      doReset();
      mLive = 1'b1;

      // Basic sequence
      step(0, 0, 0);
      chk("seq1.rs", bus.dataRs, 32'd0); chk("seq1.rt", bus.dataRt, 32'd0);
      step(0, 0, 0);
      chk("seq2.rs", bus.dataRs, 32'd1); chk("seq2.rt", bus.dataRt, 32'd2);
      step(0, 0, 0);
      chk("seq3.rs", bus.dataRs, 32'd3); chk("seq3.rt", bus.dataRt, 32'd4);

      // Jump to 0x23 -> 0x20 (word 8)
      doReset();
      step(1, 0, 32'h23);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("jump.rs", bus.dataRs, 32'd17); chk("jump.rt", bus.dataRt, 32'd18);

      // Write reg16 then read it through word 7
      doReset();
      step(0, 0, 0);
      step(0, 1, 32'hDEAD_BEEF);
      step(1, 0, 32'h1C);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("wr.rs", bus.dataRs, 32'd15); chk("wr.rt", bus.dataRt, 32'hDEAD_BEEF);

      // Register 0 ignores writes (word 15: rs 31, rt 0)
      doReset();
      step(0, 1, 32'hFFFF_FFFF);
      step(1, 0, 32'h3C);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("r0.rs", bus.dataRs, 32'd31); chk("r0.rt", bus.dataRt, 32'd0);

      // Asynchronous reset between edges, then the sequence restarts
      step(0, 1, 32'h5555_AAAA);
      step(0, 0, 0);
      #1 rst = 1'b1;
      #1;
      chk("arst.rs", bus.dataRs, 32'd0); chk("arst.rt", bus.dataRt, 32'd0);
      mReset();
      #1 rst = 1'b0;
      #2;
      step(0, 0, 0);
      step(0, 0, 0);
      chk("arst2.rs", bus.dataRs, 32'd1); chk("arst2.rt", bus.dataRt, 32'd2);

      // Same-edge write/read: word 14 has rd = rt = 30, rs = 29
      doReset();
      step(1, 0, 32'h38);
      step(0, 0, 0);
      step(0, 1, 32'h1234_5678);
      chk("byp.rs", bus.dataRs, 32'd29);
`ifdef PIPELINE_BYPASS_EN
      chk("byp.rt", bus.dataRt, 32'h1234_5678);
`else
      chk("byp.rt", bus.dataRt, 32'd30);
`endif
      step(1, 0, 32'h38);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("byp.after", bus.dataRt, 32'h1234_5678);

      // Randomized run with occasional resets
      doReset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            #1 rst = 1'b1;
            #1;
            chk("rnd.arst.rs", bus.dataRs, 32'd0);
            chk("rnd.arst.rt", bus.dataRt, 32'd0);
            mReset();
            #1 rst = 1'b0;
            #2;
         end
         step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom);
      end

      mLive = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
